// File: rtl/conv_window_engine.sv
// conv_window_engine: KxK sliding-window convolution over streamed columns with stride,
// valid/ready flow control, end-of-row marking, bias, shift, saturation and optional ReLU.
module conv_window_engine #(
    parameter int DATA_W = 16,
    parameter int W_W    = 16,
    parameter int K      = 5,
    parameter int MAP_W  = 28,
    parameter int STRIDE = 1,
    parameter int SHIFT  = 0,
    parameter int OUT_W  = DATA_W + W_W - 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 clr,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [K*DATA_W-1:0]  d_in,
    input  logic [K*K*W_W-1:0]   w_in,
    input  logic [W_W-1:0]       b_in,
    input  logic                 relu_en,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [OUT_W-1:0]     d_out,
    output logic                 out_eol
);
    localparam int ACC_W  = DATA_W + W_W + $clog2(K*K) + 1;
    localparam int P_W    = DATA_W + W_W;
    localparam int CNT_W  = $clog2(MAP_W + 1);
    localparam int LAST_N = K + ((MAP_W - K) / STRIDE) * STRIDE;
    localparam logic signed [ACC_W-1:0] SAT_MAX = {{(ACC_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] SAT_MIN = {{(ACC_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

    logic                     advance, accept, fire, last;
    logic [CNT_W-1:0]         col_cnt, nxt_col;
    logic                     win_v, win_e, s1_v, s1_e, s2_v, s2_e, s3_v, s3_e, s3_relu;
    logic signed [DATA_W-1:0] win [K][K];
    logic signed [P_W-1:0]    s1_p [K][K];
    logic signed [ACC_W-1:0]  row_sum [K];
    logic signed [ACC_W-1:0]  s2 [K];
    logic signed [ACC_W-1:0]  tot, s3, sh;
    logic [OUT_W-1:0]         res;

    assign advance  = !out_valid || out_ready;
    assign in_ready = advance;
    assign accept   = in_valid && advance && !clr;

    always_comb begin
        nxt_col = (col_cnt == CNT_W'(MAP_W)) ? CNT_W'(1) : col_cnt + CNT_W'(1);
        fire    = (int'(nxt_col) >= K) && ((int'(nxt_col) - K) % STRIDE == 0);
        last    = nxt_col == CNT_W'(LAST_N);
        tot     = '0;
        for (int r = 0; r < K; r++) begin
            row_sum[r] = '0;
            for (int c = 0; c < K; c++)
                row_sum[r] = row_sum[r] + ACC_W'(s1_p[r][c]);
            tot = tot + s2[r];
        end
        sh  = s3 >>> SHIFT;
        // ReLU after saturation: a negative saturated value is exactly a negative shifted value
        res = (s3_relu && sh[ACC_W-1]) ? '0 :
              (sh > SAT_MAX) ? SAT_MAX[OUT_W-1:0] :
              (sh < SAT_MIN) ? SAT_MIN[OUT_W-1:0] : sh[OUT_W-1:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col_cnt   <= '0;
            win_v     <= 1'b0;
            win_e     <= 1'b0;
            s1_v      <= 1'b0;
            s1_e      <= 1'b0;
            s2_v      <= 1'b0;
            s2_e      <= 1'b0;
            s3_v      <= 1'b0;
            s3_e      <= 1'b0;
            out_valid <= 1'b0;
            out_eol   <= 1'b0;
            d_out     <= '0;
        end else if (clr) begin
            col_cnt   <= '0;
            win_v     <= 1'b0;
            s1_v      <= 1'b0;
            s2_v      <= 1'b0;
            s3_v      <= 1'b0;
            out_valid <= 1'b0;
            out_eol   <= 1'b0;
        end else if (advance) begin
            if (accept)
                col_cnt <= nxt_col;
            win_v     <= accept && fire;
            win_e     <= accept && fire && last;
            s1_v      <= win_v;
            s1_e      <= win_e;
            s2_v      <= s1_v;
            s2_e      <= s1_e;
            s3_v      <= s2_v;
            s3_e      <= s2_e;
            out_valid <= s3_v;
            out_eol   <= s3_v && s3_e;
            if (s3_v)
                d_out <= res;
        end
    end

    // Datapath registers carry no reset; their contents are qualified by the valid chain.
    always_ff @(posedge clk) begin
        if (accept)
            for (int r = 0; r < K; r++) begin
                for (int c = 0; c < K - 1; c++)
                    win[r][c] <= win[r][c+1];
                win[r][K-1] <= d_in[r*DATA_W +: DATA_W];
            end
        if (advance) begin
            for (int r = 0; r < K; r++) begin
                for (int c = 0; c < K; c++)
                    s1_p[r][c] <= P_W'(win[r][c]) * P_W'($signed(w_in[(r*K+c)*W_W +: W_W]));
                s2[r] <= row_sum[r];
            end
            s3      <= tot + ACC_W'($signed(b_in));
            s3_relu <= relu_en;
        end
    end
endmodule

// File: tb/tb_conv_window_engine.sv
// tb_conv_window_engine: directed and random stimulus for conv_window_engine (stride 1 and 2)
// checked against a direct convolution model of each accepted column stream.
module tb_conv_window_engine;
    localparam int DATA_W = 16, W_W = 16, K = 5, MAP_W = 28, SHIFT = 0;
    localparam int OUT_W = DATA_W + W_W - 4;
    localparam longint MAXV = (longint'(1) << (OUT_W - 1)) - 1;
    localparam longint MINV = -(longint'(1) << (OUT_W - 1));

    logic clk = 0, rst_n = 0, clr = 0, in_valid = 0, out_ready = 1, relu_en = 0;
    logic [K*DATA_W-1:0] d_in = '0;
    logic [K*K*W_W-1:0]  w_in = '0;
    logic [W_W-1:0]      b_in = '0;
    logic                in_ready, out_valid, out_eol, in_valid2, in_ready2, out_valid2, out_eol2;
    logic [OUT_W-1:0]    d_out, d_out2, last_out = '0;

    int errors = 0, checks = 0, cyc = 0, cnt1 = 0, cnt2 = 0, m_col = 0, t5 = -1, lat = -1;
    bit stall_en = 0;
    int pixbuf [MAP_W+1][K];
    logic [OUT_W:0] q1[$], q2[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    assign in_valid2 = in_valid && in_ready;

    conv_window_engine #(.DATA_W(DATA_W), .W_W(W_W), .K(K), .MAP_W(MAP_W), .STRIDE(1), .SHIFT(SHIFT)) u_dut (
        .clk(clk), .rst_n(rst_n), .clr(clr), .in_valid(in_valid), .in_ready(in_ready),
        .d_in(d_in), .w_in(w_in), .b_in(b_in), .relu_en(relu_en), .out_valid(out_valid),
        .out_ready(out_ready), .d_out(d_out), .out_eol(out_eol));

    conv_window_engine #(.DATA_W(DATA_W), .W_W(W_W), .K(K), .MAP_W(MAP_W), .STRIDE(2), .SHIFT(SHIFT)) u_dut_s2 (
        .clk(clk), .rst_n(rst_n), .clr(clr), .in_valid(in_valid2), .in_ready(in_ready2),
        .d_in(d_in), .w_in(w_in), .b_in(b_in), .relu_en(relu_en), .out_valid(out_valid2),
        .out_ready(1'b1), .d_out(d_out2), .out_eol(out_eol2));

    task automatic check(input string tag, input longint got, input longint exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Direct convolution of the K columns ending at column n of the current row.
    function automatic logic [OUT_W-1:0] conv(input int n);
        longint acc = longint'($signed(b_in));
        for (int r = 0; r < K; r++)
            for (int c = 0; c < K; c++)
                acc += longint'(pixbuf[n-K+1+c][r]) * longint'($signed(w_in[(r*K+c)*W_W +: W_W]));
        acc = acc >>> SHIFT;
        if (acc > MAXV) acc = MAXV;
        else if (acc < MINV) acc = MINV;
        if (relu_en && acc < 0) acc = 0;
        return acc[OUT_W-1:0];
    endfunction

    always @(negedge clk) begin
        if (!rst_n) begin
            q1.delete();
            q2.delete();
            m_col = 0;
        end else begin
            if (out_valid && out_ready) begin
                cnt1++;
                last_out = d_out;
                if (lat < 0 && t5 >= 0) lat = cyc - t5;
                if (q1.size() == 0) check("s1_unexpected", {out_eol, d_out}, -1);
                else check("s1_out", {out_eol, d_out}, q1.pop_front());
            end
            if (out_valid2) begin
                cnt2++;
                if (q2.size() == 0) check("s2_unexpected", {out_eol2, d_out2}, -1);
                else check("s2_out", {out_eol2, d_out2}, q2.pop_front());
            end
            if (!out_ready) check("in_ready_stall", in_ready, !out_valid);
            if (clr) begin
                q1.delete();
                q2.delete();
                m_col = 0;
            end else if (in_valid && in_ready) begin
                m_col = (m_col == MAP_W) ? 1 : m_col + 1;
                for (int r = 0; r < K; r++) pixbuf[m_col][r] = $signed(d_in[r*DATA_W +: DATA_W]);
                if (m_col == 5 && t5 < 0) t5 = cyc + 1;
                if (m_col >= K) q1.push_back({m_col + 1 > MAP_W, conv(m_col)});
                if (m_col >= K && (m_col - K) % 2 == 0) q2.push_back({m_col + 2 > MAP_W, conv(m_col)});
            end
        end
    end

    initial forever begin
        @(posedge clk); #1;
        if (stall_en && $urandom_range(0, 9) == 0) begin
            out_ready = 0;
            repeat (3) begin @(posedge clk); #1; end
            out_ready = 1;
        end
    end

    task automatic set_w(input int mode);
        logic [W_W-1:0] v;
        for (int i = 0; i < K*K; i++) begin
            v = (mode == 0) ? 16'd1 : (mode == 1) ? ((i == 2*K) ? 16'd1 : 16'd0) :
                (mode == 2) ? 16'h7FFF : (mode == 3) ? 16'h8001 :
                (mode == 4) ? 16'($urandom_range(0, 127) - 64) : 16'($urandom);
            w_in[i*W_W +: W_W] = v;
        end
    endtask

    task automatic beat();
        int g = 0;
        in_valid = 1;
        do begin @(negedge clk); g++; end while (!in_ready && g < 50);
        check("beat_ready", in_ready, 1);
        @(posedge clk); #1;
    endtask

    task automatic row(input int mode, input int n);
        for (int c = 1; c <= n; c++) begin
            for (int r = 0; r < K; r++)
                d_in[r*DATA_W +: DATA_W] = (mode == 0) ? 16'd1 : (mode == 1) ? 16'(c) :
                                           (mode == 2) ? 16'h7FFF : 16'($urandom);
            beat();
        end
    endtask

    task automatic idle(input int n);
        in_valid = 0;
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic check_reset_outs(input string tag);
        check({tag, "_in_ready"}, in_ready, 1);
        check({tag, "_out_valid"}, out_valid, 0);
        check({tag, "_d_out"}, d_out, 0);
        check({tag, "_out_eol"}, out_eol, 0);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1 check_reset_outs("rst");
        rst_n = 1;
        set_w(0); b_in = 0;
        row(0, MAP_W); idle(10);
        check("cnt_row_s1", cnt1, 24);
        check("cnt_row_s2", cnt2, 12);
        check("latency", lat, 4);
        cnt1 = 0;
        set_w(1); b_in = 10;
        row(1, MAP_W); row(1, MAP_W); idle(10);
        check("cnt_two_rows", cnt1, 48);
        check("last_ramp", last_out, 34);
        set_w(2); b_in = 0;
        row(2, MAP_W); idle(10);
        check("sat_hi", last_out, 'h7FFFFFF);
        set_w(3);
        row(2, MAP_W); idle(10);
        check("sat_lo", last_out, 'h8000000);
        relu_en = 1;
        row(2, MAP_W); idle(10);
        check("sat_relu", last_out, 0);
        relu_en = 0;
        stall_en = 1;
        set_w(4); b_in = 16'($urandom);
        row(3, MAP_W); row(3, MAP_W); idle(30);
        relu_en = 1;
        row(3, MAP_W); idle(30);
        relu_en = 0;
        set_w(5);
        row(3, MAP_W); idle(30);
        stall_en = 0;
        idle(5);
        check("drain_s1", q1.size(), 0);
        check("drain_s2", q2.size(), 0);
        set_w(1); b_in = 10;
        row(3, 9);
        clr = 1; in_valid = 1;
        @(posedge clk); #1;
        clr = 0; in_valid = 0; cnt1 = 0;
        row(1, MAP_W); idle(10);
        check("clr_cnt", cnt1, 24);
        check("clr_last", last_out, 34);
        row(3, 10);
        rst_n = 0; in_valid = 0;
        #1 check_reset_outs("midrst");
        repeat (2) begin @(posedge clk); #1; end
        rst_n = 1; cnt1 = 0;
        row(1, MAP_W); idle(10);
        check("rst_cnt", cnt1, 24);
        check("rst_last", last_out, 34);
        check("final_s1", q1.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end
endmodule
